// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency 16-bit word memory responder with byte-enabled writes.
// One request in flight; mem_resp and mem_rdata are registered and land LATENCY cycles after acceptance.
module mem_responder #(
    parameter int LATENCY    = 3,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        proto_err
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [3:0]            count;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_read;
    logic [15:0]           mem [WORDS];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  unused_addr;

    // Byte address: bit 0 and bits above the word index fold away, so addresses wrap.
    assign idx         = mem_address[DEPTH_LOG2:1];
    assign unused_addr = ^mem_address;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            mem_resp  <= 1'b0;
            mem_rdata <= 16'h0000;
            proto_err <= 1'b0;
            req_idx   <= '0;
            req_read  <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            case (state)
                IDLE: begin
                    mem_resp <= 1'b0;
                    if (mem_read || mem_write) begin
                        state    <= BUSY;
                        count    <= 4'(LATENCY - 1);
                        req_idx  <= idx;
                        req_read <= mem_read;
                        mem_resp <= (LATENCY == 1);
                        if (mem_read) begin
                            // A simultaneous read+write is served as a read only.
                            if (mem_write) begin
                                proto_err <= 1'b1;
                            end
                            if (LATENCY == 1) begin
                                mem_rdata <= mem[idx];
                            end
                        end else begin
                            if (mem_byte_enable[0]) begin
                                mem[idx][7:0] <= mem_wdata[7:0];
                            end
                            if (mem_byte_enable[1]) begin
                                mem[idx][15:8] <= mem_wdata[15:8];
                            end
                        end
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        state    <= IDLE;
                        mem_resp <= 1'b0;
                    end else begin
                        count    <= count - 4'd1;
                        mem_resp <= (count == 4'd1);
                        if ((count == 4'd1) && req_read) begin
                            mem_rdata <= mem[req_idx];
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_resp <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed bench for mem_responder against a word-array model.
module tb_mem_responder;

    localparam int LAT  = 3;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [15:0] mem_address, mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        proto_err;

    logic        b_read, b_write;
    logic [15:0] b_address, b_wdata;
    logic [1:0]  b_byte_enable;
    logic        b_resp;
    logic [15:0] b_rdata;
    logic        b_proto_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_rdata;
    logic        ref_proto;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .proto_err(proto_err)
    );

    mem_responder #(.LATENCY(LAT1), .DEPTH_LOG2(8)) dut1 (
        .clk(clk), .reset(reset),
        .mem_read(b_read), .mem_write(b_write),
        .mem_address(b_address), .mem_wdata(b_wdata),
        .mem_byte_enable(b_byte_enable),
        .mem_resp(b_resp), .mem_rdata(b_rdata), .proto_err(b_proto_err)
    );

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        ref_rdata = 16'h0000;
        ref_proto = 1'b0;
    endfunction

    // Issue one request now, expect exactly one mem_resp LAT cycles later; inputs are scrambled while busy.
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [1:0] be, input string name);
        int          w;
        logic [15:0] hi, lo;
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_wdata = wd; mem_byte_enable = be;
        @(posedge clk);
        w = (int'(addr) / 2) % 256;
        if (rd) begin
            ref_rdata = ref_mem[w];
            if (wr) ref_proto = 1'b1;
        end else begin
            hi = be[1] ? (wd / 256) : (ref_mem[w] / 256);
            lo = be[0] ? (wd % 256) : (ref_mem[w] % 256);
            ref_mem[w] = hi * 256 + lo;
        end
        #1;
        for (int k = 1; k <= LAT + 1; k++) begin
            vectors++;
            if (mem_resp !== (k == LAT)) begin
                miscompares++;
                $display("FAIL %s resp cycle %0d: got %b expected %b", name, k, mem_resp, k == LAT);
            end
            if (k >= LAT) begin
                vectors++;
                if (mem_rdata !== ref_rdata) begin
                    miscompares++;
                    $display("FAIL %s rdata cycle %0d: got %h expected %h", name, k, mem_rdata, ref_rdata);
                end
            end
            if (k <= LAT) begin
                mem_read = 1'($urandom); mem_write = 1'($urandom);
                mem_address = 16'($urandom); mem_wdata = 16'($urandom);
                mem_byte_enable = 2'($urandom);
                @(posedge clk);
                #1;
            end else begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
        end
        vectors++;
        if (proto_err !== ref_proto) begin
            miscompares++;
            $display("FAIL %s proto_err: got %b expected %b", name, proto_err, ref_proto);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0; mem_wdata = 16'h0; mem_byte_enable = 2'b0;
        b_read = 1'b0; b_write = 1'b0; b_address = 16'h0; b_wdata = 16'h0; b_byte_enable = 2'b0;
        model_reset();
        #12;
        check_val("reset resp", 16'(mem_resp), 16'h0);
        check_val("reset rdata", mem_rdata, 16'h0000);
        check_val("reset proto", 16'(proto_err), 16'h0);
        check_val("reset b_resp", 16'(b_resp), 16'h0);
        mem_read = 1'b1; mem_address = 16'h0044;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_val("held reset resp", 16'(mem_resp), 16'h0);
        end
        reset = 1'b0;
        do_req(1'b1, 1'b0, 16'h0044, 16'h0, 2'b00, "first after reset");
    endtask

    task automatic test_directed();
        do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, "write beef");
        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "read beef");
        check_val("beef const", mem_rdata, 16'hBEEF);
        do_req(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, "write 1234");
        do_req(1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, "write hi byte");
        do_req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, "read ab34");
        check_val("ab34 const", mem_rdata, 16'hAB34);
        do_req(1'b0, 1'b1, 16'h0020, 16'h00CD, 2'b01, "write lo byte");
        do_req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, "read abcd");
        check_val("abcd const", mem_rdata, 16'hABCD);
        do_req(1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, "write be00");
        do_req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, "read after be00");
        check_val("be00 const", mem_rdata, 16'hABCD);
        do_req(1'b0, 1'b1, 16'h0002, 16'h5A5A, 2'b11, "write 5a5a");
        do_req(1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00, "read odd addr");
        check_val("odd addr const", mem_rdata, 16'h5A5A);
        do_req(1'b1, 1'b0, 16'h0202, 16'h0000, 2'b00, "read wrapped");
        check_val("wrap const", mem_rdata, 16'h5A5A);
    endtask

    task automatic test_proto();
        pulse_reset();
        do_req(1'b1, 1'b1, 16'h0030, 16'hFFFF, 2'b11, "read+write");
        check_val("proto rdata const", mem_rdata, 16'h0000);
        do_req(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, "read after proto");
        check_val("proto sticky", 16'(proto_err), 16'h1);
        pulse_reset();
        check_val("proto cleared", 16'(proto_err), 16'h0);
    endtask

    task automatic test_reset_mid_busy();
        do_req(1'b0, 1'b1, 16'h0040, 16'h1111, 2'b11, "write before reset");
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h0040;
        @(posedge clk);
        mem_read = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_val("async reset resp", 16'(mem_resp), 16'h0);
        check_val("async reset rdata", mem_rdata, 16'h0000);
        #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < LAT + 2; k++) begin
            @(posedge clk);
            #1;
            check_val("abandoned resp", 16'(mem_resp), 16'h0);
        end
        do_req(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, "read cleared word");
    endtask

    task automatic test_random();
        int          op;
        logic [15:0] a;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 9);
            a  = (n % 3 == 0) ? 16'($urandom_range(0, 15) * 2) : 16'($urandom);
            if (op == 0)
                do_req(1'b1, 1'b1, a, 16'($urandom), 2'($urandom), "rand both");
            else if (op < 5)
                do_req(1'b1, 1'b0, a, 16'($urandom), 2'($urandom), "rand read");
            else
                do_req(1'b0, 1'b1, a, 16'($urandom), 2'($urandom), "rand write");
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        b_read = 1'b1; b_write = 1'b0; b_address = 16'h0100;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (b_resp === 1'b1) pulses++;
            vectors++;
            if (b_resp !== 1'(k % 2)) begin
                miscompares++;
                $display("FAIL b2b resp cycle %0d: got %b expected %b", k, b_resp, 1'(k % 2));
            end
        end
        b_read = 1'b0;
        vectors++;
        if (pulses != 10) begin
            miscompares++;
            $display("FAIL b2b pulse count: got %0d expected 10", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_proto();
        test_reset_mid_busy();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
